fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. It holds the program counter and issues word reads to instruction memory over a request/valid handshake, with at most one read outstanding. Fetched words land in the IF/ID register, which decode and the control unit read. The unit also absorbs redirects (branch/jump) and hazard stalls, drops stale responses, and halts on a misaligned target.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if_id_reg.sv | 50 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2,
    FETCH_HALT = 2'd3
  } fetch_state_e;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats hold beats load; anything else is a bubble.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
      r_pc4   <= 32'h0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (!i_hold) begin
      if (i_load) begin
        r_valid <= 1'b1;
        r_instr <= i_instr;
        r_pc    <= i_pc;
        r_pc4   <= i_pc + 32'd4;
      end else begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem handshake, redirect/stall
// absorption through a one-entry hold buffer, and a sticky misalignment halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        fetch_fault
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_pc;
  logic         r_hold_valid;
  logic [31:0]  r_hold_instr;
  logic [31:0]  r_hold_pc;
  logic         r_fault;

  logic         w_accept;
  logic         w_rsp;
  logic         w_load;
  logic [31:0]  w_load_instr;
  logic [31:0]  w_load_pc;

  assign imem_req    = (r_state == FETCH_IDLE) && !r_hold_valid && !redirect_valid;
  assign imem_addr   = r_pc;
  assign fetch_fault = r_fault;
  assign w_accept    = imem_req && imem_ready;
  assign w_rsp       = (r_state == FETCH_WAIT) && imem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH_IDLE;
      r_pc         <= RESET_PC;
      r_hold_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else if (r_state != FETCH_HALT) begin
      if (redirect_valid) begin
        r_hold_valid <= 1'b0;
        if (misaligned(redirect_pc)) begin
          r_state <= FETCH_HALT;
          r_fault <= 1'b1;
        end else begin
          r_pc <= redirect_pc;
          case (r_state)
            FETCH_WAIT: r_state <= imem_rvalid ? FETCH_IDLE : FETCH_DROP;
            // A stale response arriving alongside a second redirect is the one
            // being waited for; nothing is left outstanding afterwards.
            FETCH_DROP: if (imem_rvalid) r_state <= FETCH_IDLE;
            default:    r_state <= FETCH_IDLE;
          endcase
        end
      end else begin
        case (r_state)
          FETCH_IDLE: begin
            if (w_accept) begin
              r_pc    <= r_pc + 32'd4;
              r_state <= FETCH_WAIT;
            end else if (r_hold_valid && !stall) begin
              r_hold_valid <= 1'b0;
            end
          end
          FETCH_WAIT: begin
            if (imem_rvalid) begin
              r_state <= FETCH_IDLE;
              if (stall) r_hold_valid <= 1'b1;
            end
          end
          FETCH_DROP: if (imem_rvalid) r_state <= FETCH_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_req_pc <= r_pc;
    if (w_rsp && stall && !redirect_valid) begin
      r_hold_instr <= imem_rdata;
      r_hold_pc    <= r_req_pc;
    end
  end

  assign w_load       = r_hold_valid || w_rsp;
  assign w_load_instr = r_hold_valid ? r_hold_instr : imem_rdata;
  assign w_load_pc    = r_hold_valid ? r_hold_pc : r_req_pc;

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_hold  (stall),
    .i_load  (w_load),
    .i_instr (w_load_instr),
    .i_pc    (w_load_pc),
    .o_valid (if_id_valid),
    .o_instr (if_id_instr),
    .o_pc    (if_id_pc),
    .o_pc4   (if_id_pc4)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory/stall/redirect traffic
// checked against a program-order model of which words must reach IF/ID.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .fetch_fault(fetch_fault)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_deliv = 0;
  int cyc = 0;
  int last_acc = -1;
  bit tput_chk = 0;

  // memory knobs and state
  int rdy_pct = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit spur_en = 0;
  bit pend = 0;
  int pend_cnt = 0;
  logic [31:0] pend_addr = 0;
  bit acc_last = 0;
  logic [31:0] addr_last = 0;

  logic [31:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // Memory: single response per accepted request after a random latency,
  // plus occasional unsolicited rvalid pulses while nothing is outstanding.
  initial begin
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_rvalid && pend && pend_cnt == 0) pend = 0;
      if (!rst_n) begin
        pend = 0;
      end else if (acc_last) begin
        check1("one_outstanding", pend, 1'b0);
        pend      = 1;
        pend_addr = addr_last;
        pend_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
      end
      if (pend && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(pend_addr);
      end else begin
        if (pend) pend_cnt--;
        imem_rvalid = spur_en && !pend && ($urandom_range(9, 0) == 0);
        imem_rdata  = $urandom;
      end
      imem_ready = ($urandom_range(99, 0) < rdy_pct);
      #1;
      acc_last  = rst_n && imem_req && imem_ready;
      addr_last = imem_addr;
    end
  end

  // Monitor: pre-edge snapshot at negedge+1, post-edge check at posedge+1.
  initial begin
    bit p_req, p_rdy, p_rd, p_st, p_rst, halted, stuck;
    logic [31:0] p_addr, p_rpc, stuck_addr, exp_req, e;
    logic        prev_v;
    logic [31:0] prev_i, prev_pc, prev_pc4;
    halted = 0; stuck = 0; stuck_addr = 0; exp_req = RST_PC;
    prev_v = 0; prev_i = NOP; prev_pc = 0; prev_pc4 = 0;
    forever begin
      @(negedge clk); #1;
      p_req = imem_req; p_rdy = imem_ready; p_addr = imem_addr;
      p_rd = redirect_valid; p_rpc = redirect_pc; p_st = stall; p_rst = rst_n;
      if (p_rst && !halted && stuck && !p_rd) begin
        check1("req_held_while_not_ready", p_req, 1'b1);
        check("addr_held_while_not_ready", p_addr, stuck_addr);
      end
      @(posedge clk); #1;
      cyc++;
      if (!p_rst || !rst_n) begin
        halted = 0; stuck = 0; exp_req = RST_PC; q.delete(); last_acc = -1;
        prev_v = if_id_valid; prev_i = if_id_instr; prev_pc = if_id_pc; prev_pc4 = if_id_pc4;
        continue;
      end
      if (halted) begin
        check1("halt_no_req", p_req, 1'b0);
        check1("halt_fault_sticky", fetch_fault, 1'b1);
        check1("halt_no_valid", if_id_valid, 1'b0);
      end else begin
        if (p_req && p_rdy) begin
          check("req_addr", p_addr, exp_req);
          q.push_back(exp_req);
          exp_req = exp_req + 32'd4;
          if (tput_chk && last_acc >= 0) check("req_spacing", 32'(cyc - last_acc), 32'd2);
          last_acc = cyc;
        end
        stuck = p_req && !p_rdy;
        stuck_addr = p_addr;
        if (p_rd) begin
          check1("no_req_during_redirect", p_req, 1'b0);
          q.delete();
          stuck = 0;
          check1("flush_valid", if_id_valid, 1'b0);
          check("flush_instr", if_id_instr, NOP);
          if (p_rpc[1:0] != 2'b00) begin
            halted = 1;
            check1("fault_on_misaligned", fetch_fault, 1'b1);
          end else begin
            exp_req = p_rpc;
            check1("no_fault", fetch_fault, 1'b0);
          end
        end else begin
          check1("no_fault", fetch_fault, 1'b0);
          if (p_st) begin
            check1("stall_hold_valid", if_id_valid, prev_v);
            check("stall_hold_instr", if_id_instr, prev_i);
            check("stall_hold_pc", if_id_pc, prev_pc);
            check("stall_hold_pc4", if_id_pc4, prev_pc4);
          end else if (if_id_valid) begin
            if (q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_delivery: got pc %h, expected no instruction", if_id_pc);
            end else begin
              e = q.pop_front();
              check("deliver_pc", if_id_pc, e);
              check("deliver_instr", if_id_instr, memf(e));
              check("deliver_pc4", if_id_pc4, e + 32'd4);
              n_deliv++;
            end
          end else begin
            check("bubble_nop", if_id_instr, NOP);
          end
        end
      end
      prev_v = if_id_valid; prev_i = if_id_instr; prev_pc = if_id_pc; prev_pc4 = if_id_pc4;
    end
  end

  task automatic wait_acc();
    int n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (!acc_last && n < 50);
    if (!acc_last) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_accept: got no accepted request, expected one within 50 cycles");
    end
  endtask

  task automatic knobs(input int rdy, input int lmin, input int lmax, input bit spur);
    @(posedge clk); #2;
    rdy_pct = rdy; lat_min = lmin; lat_max = lmax; spur_en = spur;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [31:0] r;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    check1("rst_req", imem_req, 1'b1);
    check("rst_addr", imem_addr, RST_PC);
    check1("rst_valid", if_id_valid, 1'b0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_pc4", if_id_pc4, 32'h0);
    check1("rst_fault", fetch_fault, 1'b0);

    // memory not ready for 3 cycles after reset release
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check1("notready_req", imem_req, 1'b1);
      check("notready_addr", imem_addr, RST_PC);
      @(negedge clk);
    end

    // back-to-back fetch with a 1-cycle memory
    @(posedge clk); #2; rdy_pct = 100; last_acc = -1; tput_chk = 1;
    repeat (14) @(posedge clk);
    #2; tput_chk = 0;
    check("stream_deliveries", 32'(n_deliv >= 5), 32'd1);

    // stall in the rvalid cycle parks the word in the hold buffer
    wait_acc();
    @(negedge clk); stall = 1'b1;
    #2; check1("stall_rvalid_cycle", imem_rvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check1("stall_no_req", imem_req, 1'b0);
    end
    @(negedge clk); stall = 1'b0;
    repeat (6) @(negedge clk);

    // redirect while waiting on a slow memory
    knobs(100, 3, 3, 0);
    wait_acc();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk); redirect_valid = 1'b0;
    #2; check1("drop_no_req", imem_req, 1'b0);
    repeat (15) @(negedge clk);

    // redirect + stall + rvalid in one cycle
    knobs(100, 1, 1, 0);
    wait_acc();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; stall = 1'b1;
    #2; check1("rsr_rvalid_cycle", imem_rvalid, 1'b1);
    @(negedge clk); redirect_valid = 1'b0; stall = 1'b0;
    #2;
    check1("rsr_req", imem_req, 1'b1);
    check("rsr_addr", imem_addr, 32'h0000_0200);
    repeat (6) @(negedge clk);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (12) @(negedge clk);

    // randomized traffic
    knobs(70, 1, 4, 1);
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      stall = ($urandom_range(4, 0) == 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      r = $urandom;
      if (r[0]) redirect_pc = 32'hFFFF_FFF0 + {26'h0, r[5:4], 4'h0} + {28'h0, r[3:2], 2'b00};
      else redirect_pc = {r[31:2], 2'b00};
    end
    @(negedge clk); stall = 1'b0; redirect_valid = 1'b0;
    knobs(100, 1, 1, 0);
    repeat (10) @(negedge clk);
    #2;
    check("random_progress", 32'(n_deliv - d0 > 200), 32'd1);
    check("drain_queue", 32'(q.size() <= 1), 32'd1);

    // misaligned redirect halts fetch
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk); redirect_valid = 1'b0;
    #2;
    check1("halt_fault", fetch_fault, 1'b1);
    check1("halt_req", imem_req, 1'b0);
    repeat (8) @(negedge clk);
    #2; check1("halt_req_later", imem_req, 1'b0);

    // reset pulse clears the fault and restarts at RESET_PC
    @(negedge clk); rst_n = 1'b0;
    #2;
    check1("rst2_fault", fetch_fault, 1'b0);
    check("rst2_addr", imem_addr, RST_PC);
    check1("rst2_req", imem_req, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    d0 = n_deliv;
    repeat (10) @(negedge clk);
    #2; check("restart_progress", 32'(n_deliv - d0 >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
